gray_step_decoder: RTL and testbench
====================================

Name: gray_step_decoder

Overview:
- Receive-side companion to the team's 3-bit Gray up/down counter.
- Samples an asynchronous Gray-coded bus, such as a Gray counter output or an absolute encoder, and converts it to binary position.
- Detects single-step up/down transitions and accumulates a signed step count.
- Flags illegal multi-bit jumps; sits between the Gray source and the control logic that consumes position and direction.

Parameters:
W, 3, Gray bus width (2..8)
SYNC_STAGES, 2, synchronizer flop depth (>=2)
CNT_W, 16, signed step-count width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
gray_in  in  W  asynchronous Gray-coded input
clr  in  1  synchronous clear of count/error, restarts capture
pos  out  W  binary position of last accepted sample
step_valid  out  1  one-cycle pulse per accepted legal step
step_dir  out  1  1=up, 0=down; valid with step_valid
count  out  CNT_W  signed accumulated steps (two's complement)
err  out  1  one-cycle pulse on illegal jump
err_sticky  out  1  held high from illegal jump until clr or reset

Behaviour:
- Reset (async, active-low): sync chain, prev, pos, count, step_valid, step_dir, err, err_sticky all 0; settle counter 0; state S_INIT.
- Input path: gray_in passes through SYNC_STAGES flops, then gray-to-binary conversion gives cur (combinational from last sync flop).
- All outputs are registered.
- S_INIT:
  - Settle counter counts SYNC_STAGES+1 cycles.
  - On final count: prev<=cur, pos<=cur, go S_TRACK.
  - No step_valid or err in S_INIT.
- S_TRACK, each cycle with delta=(cur-prev) mod 2^W:
  - delta=0: no action.
  - delta=1: step_valid=1, step_dir=1, count+=1, prev/pos<=cur.
  - delta=2^W-1: step_valid=1, step_dir=0, count-=1, prev/pos<=cur.
  - Otherwise: err=1, err_sticky<=1, pos/prev<=cur, count unchanged, go S_FAULT.
- S_FAULT:
  - pos keeps tracking cur.
  - No step_valid or err pulses; count frozen; err_sticky stays 1.
  - Exits only on clr.
- Wrap-around: binary (2^W-1)->0 is up; 0->(2^W-1) is down. With W=3 these are Gray 100->000 and 000->100.
- Count overflow wraps two's complement: 0x7FFF+1 = 0x8000 for CNT_W=16. No saturation.
- clr, any state: count<=0, err_sticky<=0, step_valid/err<=0, settle counter<=0, go S_INIT.
  - pos is held until recapture.
  - clr wins over a simultaneous step or error; that event is dropped.
- Latency: a legal step on gray_in, stable before edge k, produces step_valid high in the cycle following edge k+SYNC_STAGES.
- Reset asserted mid-operation clears everything immediately, without waiting for clk.

Optional Feature:
- Macro: GRAY_DEC_DEBOUNCE_EN.
- Defined:
  - cur must be equal on two consecutive cycles before it is compared against prev.
  - Adds exactly 1 cycle of latency.
  - A value present for a single cycle is ignored, with no step and no err.
  - INIT settle count becomes SYNC_STAGES+2.
- Undefined: cur is compared every cycle as described above.

Decomposition:
- Package gray_pkg:
  - state enum {S_INIT, S_TRACK, S_FAULT} as logic [1:0].
  - gray2bin and bin2gray parameterised functions; bin2gray is also used by benches to generate stimulus.
- Sub-module gray_sync: SYNC_STAGES-deep W-bit synchronizer with async active-low reset to 0.

Test Plan:
- W=3, SYNC_STAGES=2; gray_in=000 through reset release -> after 3 cycles: state S_TRACK, pos=0, count=0, no step_valid/err.
- Up cycle 000,001,011,010,110,111,101,100,000, each held 4 cycles -> 8 step_valid pulses with step_dir=1; count=8; pos ends 0; err_sticky=0.
- From 000 drive 100 -> one step_valid, step_dir=0, pos=7, count=0xFFFF (-1).
- From 000 drive 010 (bin 3) -> err pulse, err_sticky=1, pos=3, count unchanged. Then legal step 010->110 -> no step_valid, pos=4. Then clr -> err_sticky=0, re-enters S_TRACK after 3 cycles with prev=4.
- Force count=0x7FFF via 32767 up steps, then one more up step -> count=0x8000, no err.
- clr on the same cycle a step is detected -> count=0, no step_valid. Separately, assert reset mid-sequence -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/gray_pkg.sv
// ============================================================================
// gray_pkg: shared FSM state type and Gray/binary conversion helpers.
// Rev 1.0
// ============================================================================
`default_nettype none

package gray_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int c_MAX_W = 8;

  // Operate at the widest supported bus; zero upper bits leave narrower codes intact.
  function automatic logic [c_MAX_W-1:0] gray2bin(input logic [c_MAX_W-1:0] g);
    logic [c_MAX_W-1:0] b;
    b[c_MAX_W-1] = g[c_MAX_W-1];
    for (int i = c_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [c_MAX_W-1:0] bin2gray(input logic [c_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sync.sv
// ============================================================================
// gray_sync: SYNC_STAGES-deep, W-bit flop synchronizer, async active-low reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_sync #(
  parameter int W           = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_step_decoder.sv
// ============================================================================
// gray_step_decoder: synchronizes a Gray bus, tracks single steps into a
// signed count and flags illegal jumps. Optional: GRAY_DEC_DEBOUNCE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int W           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     gray_in,
  input  logic             clr,
  output logic [W-1:0]     pos,
  output logic             step_valid,
  output logic             step_dir,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             err_sticky
);

`ifdef GRAY_DEC_DEBOUNCE_EN
  localparam int c_SETTLE = SYNC_STAGES + 2;
`else
  localparam int c_SETTLE = SYNC_STAGES + 1;
`endif
  localparam int c_SET_W = $clog2(c_SETTLE + 1);

  logic [W-1:0]       w_sync;
  logic [W-1:0]       w_cur;
  logic [W-1:0]       w_delta;
  logic               w_stable;

  state_t             r_state, w_state_nxt;
  logic [c_SET_W-1:0] r_settle, w_settle_nxt;
  logic [W-1:0]       r_prev, w_prev_nxt;
  logic [W-1:0]       r_pos, w_pos_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_step_valid, w_step_valid_nxt;
  logic               r_step_dir, w_step_dir_nxt;
  logic               r_err, w_err_nxt;
  logic               r_err_sticky, w_err_sticky_nxt;

  gray_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gray_in),
    .q     (w_sync)
  );

  assign w_cur = W'(gray2bin(c_MAX_W'(w_sync)));

`ifdef GRAY_DEC_DEBOUNCE_EN
  logic [W-1:0] r_cur_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_d <= '0;
    end else begin
      r_cur_d <= w_cur;
    end
  end

  // A sample is only trusted once it has been seen on two consecutive cycles.
  assign w_stable = (w_cur == r_cur_d);
`else
  assign w_stable = 1'b1;
`endif

  assign w_delta = w_cur - r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_INIT;
      r_settle     <= '0;
      r_prev       <= '0;
      r_pos        <= '0;
      r_count      <= '0;
      r_step_valid <= 1'b0;
      r_step_dir   <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle     <= w_settle_nxt;
      r_prev       <= w_prev_nxt;
      r_pos        <= w_pos_nxt;
      r_count      <= w_count_nxt;
      r_step_valid <= w_step_valid_nxt;
      r_step_dir   <= w_step_dir_nxt;
      r_err        <= w_err_nxt;
      r_err_sticky <= w_err_sticky_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_settle_nxt     = r_settle;
    w_prev_nxt       = r_prev;
    w_pos_nxt        = r_pos;
    w_count_nxt      = r_count;
    w_step_valid_nxt = 1'b0;
    w_step_dir_nxt   = r_step_dir;
    w_err_nxt        = 1'b0;
    w_err_sticky_nxt = r_err_sticky;

    // clr overrides any step or error detected in the same cycle.
    if (clr) begin
      w_count_nxt      = '0;
      w_err_sticky_nxt = 1'b0;
      w_settle_nxt     = '0;
      w_state_nxt      = S_INIT;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_settle == c_SET_W'(c_SETTLE - 1)) begin
            w_prev_nxt  = w_cur;
            w_pos_nxt   = w_cur;
            w_state_nxt = S_TRACK;
          end else begin
            w_settle_nxt = r_settle + c_SET_W'(1);
          end
        end
        S_TRACK: begin
          if (w_stable && (w_delta != '0)) begin
            w_prev_nxt = w_cur;
            w_pos_nxt  = w_cur;
            if (w_delta == W'(1)) begin
              w_step_valid_nxt = 1'b1;
              w_step_dir_nxt   = 1'b1;
              w_count_nxt      = r_count + CNT_W'(1);
            end else if (w_delta == '1) begin
              w_step_valid_nxt = 1'b1;
              w_step_dir_nxt   = 1'b0;
              w_count_nxt      = r_count - CNT_W'(1);
            end else begin
              w_err_nxt        = 1'b1;
              w_err_sticky_nxt = 1'b1;
              w_state_nxt      = S_FAULT;
            end
          end
        end
        S_FAULT: begin
          w_pos_nxt        = w_cur;
          w_prev_nxt       = w_cur;
          w_err_sticky_nxt = 1'b1;
        end
        default: begin
          w_state_nxt  = S_INIT;
          w_settle_nxt = '0;
        end
      endcase
    end
  end

  assign pos        = r_pos;
  assign step_valid = r_step_valid;
  assign step_dir   = r_step_dir;
  assign count      = r_count;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_gray_step_decoder.sv
// ============================================================================
// tb_gray_step_decoder: directed, self-checking bench for gray_step_decoder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gray_step_decoder;
  import gray_pkg::*;

  localparam int W  = 3;
  localparam int SS = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic [W-1:0]  pos;
  logic          step_valid;
  logic          step_dir;
  logic [CW-1:0] count;
  logic          err;
  logic          err_sticky;

  int total = 0;
  int bad = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int err_cnt = 0;
  int b = 0;
  int u0 = 0;
  int e0 = 0;

  gray_step_decoder #(
    .W           (W),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_in    (gray_in),
    .clr        (clr),
    .pos        (pos),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .count      (count),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Pulse tally sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (step_valid) begin
      if (step_dir) up_cnt++;
      else dn_cnt++;
    end
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int v);
    gray_in = W'(bin2gray(c_MAX_W'(v)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cyc(2);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_step_valid", 32'(step_valid), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    reset = 1'b1;
    cyc(3);
    check("init_state", 32'(dut.r_state), 32'(S_TRACK));
    check("init_pos", 32'(pos), 32'd0);
    check("init_count", 32'(count), 32'd0);
    check("init_no_pulses", 32'(up_cnt + dn_cnt + err_cnt), 32'd0);

    // Full up cycle with wrap 7->0
    for (int i = 1; i <= 8; i++) begin
      drive(i % 8);
      cyc(4);
    end
    check("up_pulses", 32'(up_cnt), 32'd8);
    check("up_no_down", 32'(dn_cnt), 32'd0);
    check("up_count", 32'(count), 32'd8);
    check("up_pos", 32'(pos), 32'd0);
    check("up_err_sticky", 32'(err_sticky), 32'd0);

    // clr then down step 0->7 with latency checks
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(4);
    check("clr_count", 32'(count), 32'd0);
    check("clr_state", 32'(dut.r_state), 32'(S_TRACK));
    drive(7);
    cyc(1);
    check("lat_edge0", 32'(step_valid), 32'd0);
    cyc(1);
    check("lat_edge1", 32'(step_valid), 32'd0);
    cyc(1);
    check("dn_valid", 32'(step_valid), 32'd1);
    check("dn_dir", 32'(step_dir), 32'd0);
    cyc(1);
    check("dn_pulse_end", 32'(step_valid), 32'd0);
    check("dn_pos", 32'(pos), 32'd7);
    check("dn_count", 32'(count), 32'h0000_FFFF);

    // Back to 0, then illegal jump 0->3
    drive(0);
    cyc(4);
    check("ret_count", 32'(count), 32'd0);
    drive(3);
    cyc(3);
    check("err_pulse", 32'(err), 32'd1);
    check("err_no_step", 32'(step_valid), 32'd0);
    cyc(1);
    check("err_pulse_end", 32'(err), 32'd0);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
    check("err_pos", 32'(pos), 32'd3);
    check("err_count", 32'(count), 32'd0);
    check("err_state", 32'(dut.r_state), 32'(S_FAULT));

    // Legal step while faulted: pos tracks, nothing else
    u0 = up_cnt;
    drive(4);
    cyc(4);
    check("fault_no_step", 32'(up_cnt), 32'(u0));
    check("fault_pos", 32'(pos), 32'd4);
    check("fault_sticky", 32'(err_sticky), 32'd1);
    check("fault_count", 32'(count), 32'd0);

    // clr recovers; recapture prev=4 so 4->5 is an up step
    clr = 1'b1;
    cyc(1);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    clr = 1'b0;
    cyc(4);
    check("reclr_state", 32'(dut.r_state), 32'(S_TRACK));
    drive(5);
    cyc(4);
    check("recap_count", 32'(count), 32'd1);
    check("recap_step", 32'(up_cnt), 32'(u0 + 1));
    check("recap_pos", 32'(pos), 32'd5);

    // Count overflow 0x7FFF -> 0x8000
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(4);
    b = 5;
    for (int i = 0; i < 32767; i++) begin
      b = (b + 1) % 8;
      drive(b);
      cyc(2);
    end
    cyc(3);
    check("ovf_max", 32'(count), 32'h0000_7FFF);
    e0 = err_cnt;
    b = (b + 1) % 8;
    drive(b);
    cyc(4);
    check("ovf_wrap", 32'(count), 32'h0000_8000);
    check("ovf_no_err", 32'(err_cnt), 32'(e0));
    check("ovf_sticky", 32'(err_sticky), 32'd0);

    // clr coincident with a detected step drops the step
    u0 = up_cnt;
    b = (b + 1) % 8;
    drive(b);
    cyc(2);
    clr = 1'b1;
    cyc(1);
    check("coll_no_step", 32'(step_valid), 32'd0);
    check("coll_count", 32'(count), 32'd0);
    clr = 1'b0;
    cyc(4);
    check("coll_up_cnt", 32'(up_cnt), 32'(u0));
    check("coll_pos", 32'(pos), 32'(b));

    // Async reset mid-cycle after a step and an error
    b = (b + 1) % 8;
    drive(b);
    cyc(4);
    check("pre_rst_count", 32'(count), 32'd1);
    b = (b + 3) % 8;
    drive(b);
    cyc(4);
    check("pre_rst_sticky", 32'(err_sticky), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_pos", 32'(pos), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_step_valid", 32'(step_valid), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_sticky", 32'(err_sticky), 32'd0);
    check("arst_state", 32'(dut.r_state), 32'(S_INIT));
    reset = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
